// File: rtl/i2s_mic_receiver_if.sv
// Signal bundle between the I2S microphone receiver and its surroundings:
// serial data in from the mic, generated clocks out, captured samples out.
interface i2s_mic_receiver_if;
    logic               i2s_sd_in;
    logic               i2s_sck_out;
    logic               i2s_ws_out;
    logic signed [15:0] raw_audio_single_cycle;
    logic               mic_data_valid;

    modport master (
        input  i2s_sd_in,
        output i2s_sck_out,
        output i2s_ws_out,
        output raw_audio_single_cycle,
        output mic_data_valid
    );

    modport slave (
        output i2s_sd_in,
        input  i2s_sck_out,
        input  i2s_ws_out,
        input  raw_audio_single_cycle,
        input  mic_data_valid
    );
endinterface

// File: rtl/i2s_mic_receiver.sv
// I2S master receiver for a 24-bit MEMS microphone: generates SCK/WS, captures
// the top 16 bits of one slot per frame and presents them with a 1-cycle strobe.
module i2s_mic_receiver #(
    parameter int SCK_HALF = 16,
    parameter int CHANNEL  = 0
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    i2s_mic_receiver_if.master bus
);
    localparam logic [7:0] DIV_LAST    = 8'(SCK_HALF - 1);
    localparam logic       SLOT        = CHANNEL[0];
    localparam int         SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             div_cnt_q, div_cnt_d;
    logic                   sck_q, sck_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic                   ws_q, ws_d;
    logic [15:0]            shift_q, shift_d;
    logic                   capture_q, capture_d;
    logic [15:0]            sample_q, sample_d;
    logic                   valid_q, valid_d;

    logic div_wrap;
    logic sck_rise;
    logic sck_fall;
    logic in_slot;
    logic sd_sync;

    assign sd_sync  = sync_q[SYNC_STAGES-1];
    assign div_wrap = (div_cnt_q == DIV_LAST);
    assign sck_rise = div_wrap & ~sck_q;
    assign sck_fall = div_wrap &  sck_q;
    // Slot bit 0 carries the previous word's LSB; the MSB arrives at index 1.
    assign in_slot  = (bit_cnt_q[5] == SLOT) &&
                      (bit_cnt_q[4:0] >= 5'd1) && (bit_cnt_q[4:0] <= 5'd16);

    always_comb begin
        div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
        sck_d     = sck_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        capture_d = 1'b0;
        sample_d  = sample_q;
        valid_d   = capture_q;

        if (div_wrap) begin
            sck_d = ~sck_q;
        end
        if (sck_fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
        end
        ws_d = bit_cnt_d[5];

        if (sck_rise && in_slot) begin
            shift_d   = {shift_q[14:0], sd_sync};
            capture_d = (bit_cnt_q[4:0] == 5'd16);
        end
        // Capture lags the final shift by one cycle so the full word is in shift_q.
        if (capture_q) begin
            sample_d = shift_q;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            sync_q    <= '0;
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            bit_cnt_q <= '0;
            ws_q      <= 1'b0;
            shift_q   <= '0;
            capture_q <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.i2s_sd_in};
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= ws_d;
            shift_q   <= shift_d;
            capture_q <= capture_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.i2s_sck_out            = sck_q;
    assign bus.i2s_ws_out             = ws_q;
    assign bus.raw_audio_single_cycle = sample_q;
    assign bus.mic_data_valid         = valid_q;
endmodule

// File: tb/tb_i2s_mic_receiver.sv
// Bench for i2s_mic_receiver: mic models feed left/right instances, a scoreboard
// holds expected (cycle, sample) pairs and a monitor checks clocks and pulses.
module tb_i2s_mic_receiver;
    localparam int SCK_HALF = 16;
    localparam int FRAME    = 128 * SCK_HALF;
    localparam int FIRST0   = 33 * SCK_HALF + 1;
    localparam int FIRST1   = 97 * SCK_HALF + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic rst_edge = 1'b0;
    int   cyc      = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [23:0] lw[2];
    logic [23:0] rw[2];

    logic [5:0]  mcnt[2];
    logic        prev_msck[2];

    int          last_rise[2];
    int          last_ws[2];
    logic        prev_sck[2];
    logic        prev_ws[2];
    logic        prev_vld[2];
    logic [15:0] hold[2];

    i2s_mic_receiver_if bus0();
    i2s_mic_receiver_if bus1();

    i2s_mic_receiver #(.SCK_HALF(SCK_HALF), .CHANNEL(0)) dut0 (
        .audio_clk (clk),
        .rst_in    (rst),
        .bus       (bus0)
    );

    i2s_mic_receiver #(.SCK_HALF(SCK_HALF), .CHANNEL(1)) dut1 (
        .audio_clk (clk),
        .rst_in    (rst),
        .bus       (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_edge <= rst;
        cyc      <= rst ? 0 : cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Mic model: presents the next bit after every SCK falling edge, MSB at slot index 1.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        s;
            logic        b;
            logic [23:0] w;
            int          idx;
            s = (d == 0) ? bus0.i2s_sck_out : bus1.i2s_sck_out;
            if (rst_edge) begin
                mcnt[d]      = 6'd0;
                prev_msck[d] = 1'b0;
            end else begin
                if (prev_msck[d] && !s) mcnt[d] = mcnt[d] + 6'd1;
                prev_msck[d] = s;
            end
            w   = mcnt[d][5] ? rw[d] : lw[d];
            idx = int'(mcnt[d][4:0]);
            b   = 1'b0;
            if (idx >= 1 && idx <= 24) b = w[24 - idx];
            if (d == 0) bus0.i2s_sd_in = b;
            else        bus1.i2s_sd_in = b;
        end
    end

    // Monitor: reset values, SCK/WS periods, pulse width, scoreboard and hold checks.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        sck;
            logic        ws;
            logic        vld;
            logic [15:0] dat;
            exp_t        e;
            int          qs;
            sck = (d == 0) ? bus0.i2s_sck_out : bus1.i2s_sck_out;
            ws  = (d == 0) ? bus0.i2s_ws_out  : bus1.i2s_ws_out;
            vld = (d == 0) ? bus0.mic_data_valid : bus1.mic_data_valid;
            dat = (d == 0) ? bus0.raw_audio_single_cycle : bus1.raw_audio_single_cycle;
            if (rst_edge) begin
                check($sformatf("ch%0d_rst_sck", d), 32'(sck), 32'd0);
                check($sformatf("ch%0d_rst_ws", d), 32'(ws), 32'd0);
                check($sformatf("ch%0d_rst_valid", d), 32'(vld), 32'd0);
                check($sformatf("ch%0d_rst_data", d), {16'h0, dat}, 32'd0);
                last_rise[d] = -SCK_HALF;
                last_ws[d]   = 0;
                prev_sck[d]  = 1'b0;
                prev_ws[d]   = 1'b0;
                prev_vld[d]  = 1'b0;
                hold[d]      = 16'h0;
            end else begin
                if (sck && !prev_sck[d]) begin
                    check($sformatf("ch%0d_sck_period", d), cyc - last_rise[d], 2 * SCK_HALF);
                    last_rise[d] = cyc;
                end
                if (ws != prev_ws[d]) begin
                    check($sformatf("ch%0d_ws_half", d), cyc - last_ws[d], FRAME / 2);
                    last_ws[d] = cyc;
                end
                if (vld) begin
                    check($sformatf("ch%0d_valid_width", d), 32'(prev_vld[d]), 32'd0);
                    qs = (d == 0) ? q0.size() : q1.size();
                    check($sformatf("ch%0d_expected_pulse", d), 32'(qs != 0), 32'd1);
                    if (qs != 0) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("ch%0d_pulse_cycle", d), cyc, e.cyc);
                        check($sformatf("ch%0d_sample", d), {16'h0, dat}, {16'h0, e.data});
                        $display("[TB] ch%0d pulse at cycle %0d data 0x%04h (exp cycle %0d data 0x%04h)",
                                 d, cyc, dat, e.cyc, e.data);
                        hold[d] = e.data;
                    end
                end else begin
                    check($sformatf("ch%0d_hold", d), {16'h0, dat}, {16'h0, hold[d]});
                end
                prev_sck[d] = sck;
                prev_ws[d]  = ws;
                prev_vld[d] = vld;
            end
        end
    end

    task automatic push_frames(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cyc  = FIRST0 + FRAME * i;
            e.data = lw[0][23:8];
            q0.push_back(e);
            e.cyc  = FIRST1 + FRAME * i;
            e.data = rw[1][23:8];
            q1.push_back(e);
        end
    endtask

    task automatic start_test(input logic [23:0] l0, input logic [23:0] r0,
                              input logic [23:0] l1, input logic [23:0] r1, input int frames);
        @(negedge clk);
        rst   = 1'b1;
        lw[0] = l0;
        rw[0] = r0;
        lw[1] = l1;
        rw[1] = r1;
        push_frames(frames);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finish_test(input string name);
        check({name, "_ch0_leftover"}, q0.size(), 0);
        check({name, "_ch1_leftover"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        bus0.i2s_sd_in = 1'b0;
        bus1.i2s_sd_in = 1'b0;
        lw[0] = '0; rw[0] = '0; lw[1] = '0; rw[1] = '0;

        // Positive full scale on left, ch1 takes right word; 10 frames of timing.
        start_test(24'h7FFF00, 24'h000000, 24'h123456, 24'hABCDEF, 10);
        repeat (10 * FRAME) @(negedge clk);
        finish_test("full_scale");

        // Most negative sample; low byte only on ch1's slot.
        start_test(24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h0001FF, 3);
        repeat (3 * FRAME) @(negedge clk);
        finish_test("neg_lowbyte");

        // Low byte toggles on ch0 with a busy opposite slot.
        start_test(24'h0001FF, 24'hFFFFFF, 24'hFFFFFF, 24'h800000, 3);
        repeat (3 * FRAME) @(negedge clk);
        finish_test("ignore_bits");

        // Reset during left bit 10 of the second frame discards that word.
        start_test(24'h5A5A00, 24'h000000, 24'h000000, 24'h8000FF, 1);
        repeat (FRAME + 330) @(negedge clk);
        rst = 1'b1;
        finish_test("pre_reset");
        push_frames(2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        finish_test("mid_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/i2s_mic_receiver.md
I2S_MIC_RECEIVER -- requirements
Module: i2s_mic_receiver

Interface
REQ-001 Parameter SCK_HALF, default 16, audio_clk cycles per SCK half-period (98.304 MHz -> 3.072 MHz SCK, 48 kHz frames); legal range 4..255.
REQ-002 Parameter CHANNEL, default 0, slot captured: 0 = left (WS low), 1 = right (WS high).
REQ-003 audio_clk  input  1  sole clock; every register SHALL be clocked on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 i2s_sd_in  input  1  asynchronous serial data from the I2S MEMS mic, MSB-first, 24-bit two's complement.
REQ-006 i2s_sck_out  output  1  generated I2S bit clock, registered.
REQ-007 i2s_ws_out  output  1  generated word select, registered; low = left slot, high = right slot.
REQ-008 raw_audio_single_cycle  output  16  signed; top 16 bits of the captured 24-bit word.
REQ-009 mic_data_valid  output  1  one-audio_clk-cycle pulse; raw_audio_single_cycle is valid in that cycle.

Function
REQ-010 i2s_sd_in SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Divider counter div_cnt SHALL count 0..SCK_HALF-1 and wrap; i2s_sck_out SHALL toggle on each wrap.
REQ-012 6-bit bit_cnt SHALL increment, wrapping 63->0, on every SCK falling transition (high->low).
REQ-013 i2s_ws_out SHALL equal bit_cnt[5]; frame = 64 SCK periods, 32 per slot.
REQ-014 I2S timing: the MSB of a slot SHALL be sampled during slot bit index 1, one SCK after the WS change.
REQ-015 On each SCK rising transition, the synchronized SD SHALL be shifted into a 16-bit shift register when bit_cnt[5] == CHANNEL and bit_cnt[4:0] is in 1..16; all other bits SHALL be ignored.
REQ-016 After the shift at slot bit index 16, the shift register SHALL be copied to raw_audio_single_cycle on the next audio_clk edge, with mic_data_valid high for exactly that one cycle.
REQ-017 Exactly one mic_data_valid pulse SHALL occur per 64-SCK frame (48 kHz at defaults); the pulse SHALL never be wider than one cycle.
REQ-018 raw_audio_single_cycle SHALL hold its value between pulses.
REQ-019 Timing from reset release (cycle 0): SCK rising edge of period k SHALL occur at cycle (2k+1)*SCK_HALF, falling edge at (2k+2)*SCK_HALF.
REQ-020 First valid pulse after reset SHALL occur at cycle 33*SCK_HALF+1 for CHANNEL=0 (529 at default) and 97*SCK_HALF+1 for CHANNEL=1.
REQ-021 No arithmetic SHALL be applied to the sample: sign is preserved by truncation of the low 8 bits, with no rounding or saturation.

Reset
REQ-022 While rst_in is high: div_cnt=0, bit_cnt=0, i2s_sck_out=0, i2s_ws_out=0, shift register=0, raw_audio_single_cycle=0, mic_data_valid=0, synchronizer flops=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial word; no valid pulse SHALL be produced for it, and timing SHALL restart per REQ-019.
REQ-024 Reset SHALL take priority over all other updates in the same cycle.

Verification
REQ-025 Mic model drives left word 0x7FFF00 and right word 0x000000 on SCK falling edges, CHANNEL=0 -> pulse at cycle 529 with output 0x7FFF, then pulses every 2048 cycles.
REQ-026 Left word 0x800000 (most negative) -> output 0x8000, signed -32768.
REQ-027 CHANNEL=1, left word 0x123456, right word 0xABCDEF -> output 0xABCD, first pulse at cycle 1553.
REQ-028 Low byte toggling only (left word 0x0001FF) -> output 0x0001, proving bits 17..31 are ignored.
REQ-029 rst_in pulsed for 3 cycles during left bit 10 -> no pulse for that frame; next pulse 529 cycles after reset release; SCK and WS low during reset.
REQ-030 Over 10 frames: i2s_sck_out period = 32 cycles, i2s_ws_out period = 2048 cycles at 50% duty, and mic_data_valid count = 10, each pulse 1 cycle wide.
